sseg_disp_mux: RTL and testbench
================================

Name: sseg_disp_mux

Overview:
- Downstream consumer of the stopwatch digit counters: takes four 4-bit BCD digits plus decimal-point flags.
- Time-multiplexes them onto a common-anode 4-digit seven-segment display.
- Captures inputs coherently once per refresh frame, so a counter carry never shows as a torn reading.
- Sits between the stopwatch and the board display pins.

Parameters:
REFRESH_DVSR, 50000, clk cycles each digit stays lit (50 MHz -> 1 kHz per digit, 250 Hz frame)
REFRESH_W, 16, width of refresh counter; must satisfy 2^REFRESH_W > REFRESH_DVSR

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (asserted at 0); clears all state
en  in  1  display enable; 0 blanks all digits and freezes scanning
d0  in  4  BCD digit 0 (rightmost)
d1  in  4  BCD digit 1
d2  in  4  BCD digit 2
d3  in  4  BCD digit 3 (leftmost)
dp_in  in  4  decimal-point request, bit i for digit i, 1 = lit
an  out  4  anode selects, active-low, one-hot-zero
sseg  out  8  segments active-low, bit7 = dp, bits6..0 = g,f,e,d,c,b,a

Behaviour:
- Reset values:
  - refresh counter = 0, digit index = 0, shadow digits/dp = 0
  - an = 4'b1111, sseg = 8'hFF (all dark)
- Refresh counter:
  - Increments each clk while en = 1.
  - At REFRESH_DVSR-1 it wraps to 0 and issues a one-cycle scan tick.
- Digit index: 2-bit state 0 -> 1 -> 2 -> 3 -> 0, advancing on the scan tick.
- Frame capture:
  - On the scan tick with index = 3, shadow <= {d3,d2,d1,d0,dp_in} on the same edge that index -> 0.
  - Inputs are otherwise ignored.
  - First capture happens at the first 3 -> 0 wrap after reset; until then shadow = 0, so zeros are shown.
- Output register:
  - an/sseg are registered from decode(index, shadow, en): 1 clk latency after any index/shadow/en change.
  - an[i] = 0 only for i = index; all others 1.
- Segment code (g..a, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10..15 (invalid BCD) show dash = 0111111.
- sseg[7] = ~shadow_dp[index].
- en = 0: next output an = 1111 and sseg = 8'hFF; counter and index hold their values. Scanning resumes from the held state when en returns to 1.
- Reset mid-frame: immediate asynchronous return to reset values; partially scanned frame discarded.
- en sampled on the same edge as a capture tick: no tick occurs (counter frozen), so no capture.

Optional Feature:
- Macro: SSEG_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - Digit 3 blanked (sseg = 8'hFF, anode still driven) when shadow d3 = 0.
  - Digit 2 blanked when d3 = d2 = 0; digit 1 blanked when d3 = d2 = d1 = 0.
  - Digit 0 never blanked.
  - A set dp on a blanked digit still lights the dp: sseg = 8'h7F.
- Undefined: all four digits always displayed, zeros included.

Decomposition:
- Package sseg_pkg:
  - segment code constants SEG_0..SEG_9, SEG_DASH, SEG_OFF
  - N_DIGITS = 4
  - digit-index typedef (2-bit)
- One natural combinational sub-module, bcd_to_sseg: 4-bit digit in, 7-bit active-low segments out, dash for 10..15.

Test Plan (REFRESH_DVSR = 4):
- Reset release with d = 9,8,7,6 (d3..d0): an = 1111/sseg = FF during reset; after 1 clk an = 1110, sseg = C0 (zeros, nothing captured); after first full frame (16 clk) digit 0 shows sseg = 82 (6), an cycles 1110, 1101, 1011, 0111 every 4 clk.
- Coherence: change d0 from 3 to 4 while index = 1 -> displayed d0 stays 3 until next 3 -> 0 wrap, then shows 4 (sseg = 99) one clk after wrap.
- Invalid BCD d2 = 4'hC -> digit 2 shows sseg = BF (dash); dp_in = 0100 -> digit 2 shows sseg = 3F.
- en deasserted mid-digit-2 -> next clk an = 1111, sseg = FF; re-enable after 10 clk -> digit 2 relit, remaining dwell = cycles left before freeze.
- Async reset pulsed at index = 2 mid-count -> an = 1111, sseg = FF with no clk edge; scan restarts at index 0.
- With SSEG_LZ_BLANK_EN, digits 0,0,5,0 (d3..d0) -> digit 3 dark (FF), digit 2 dark, digit 1 = 92, digit 0 = C0. Without the macro, digits 3 and 2 show C0.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared constants and types for the multiplexed seven-segment display driver.
// Segment codes are active-low, bit order g,f,e,d,c,b,a.
package sseg_pkg;

    localparam int unsigned N_DIGITS = 4;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef logic [1:0] digit_idx_t;

    // One coherent snapshot of everything the display shows for a frame.
    typedef struct packed {
        logic [N_DIGITS-1:0][3:0] digit;
        logic [N_DIGITS-1:0]      dp;
    } frame_t;

endpackage

// File: rtl/bcd_to_sseg.sv
// BCD digit to active-low seven-segment pattern; non-BCD codes render as a dash.
module bcd_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/sseg_disp_mux.sv
// Four-digit common-anode display multiplexer with once-per-frame input capture.
// Define SSEG_LZ_BLANK_EN to blank leading zeros on digits 3..1.
module sseg_disp_mux
    import sseg_pkg::*;
#(
    parameter int unsigned REFRESH_DVSR = 50000,
    parameter int unsigned REFRESH_W    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] dp_in,
    output logic [3:0] an,
    output logic [7:0] sseg
);

    localparam logic [REFRESH_W-1:0] CNT_MAX = REFRESH_W'(REFRESH_DVSR - 1);

    logic [REFRESH_W-1:0] cnt_q, cnt_d;
    digit_idx_t           idx_q, idx_d;
    frame_t               shadow_q, shadow_d;
    logic [3:0]           an_q, an_d;
    logic [7:0]           sseg_q, sseg_d;
    logic                 tick;
    logic [3:0]           cur_digit;
    logic [6:0]           cur_seg;
    logic                 blank;

    // Counter freezes while disabled, so a tick can never coincide with en = 0.
    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        tick     = 1'b0;
        if (en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (tick) begin
            idx_d = digit_idx_t'(idx_q + 2'd1);
            if (idx_q == digit_idx_t'(N_DIGITS - 1)) begin
                shadow_d.digit = {d3, d2, d1, d0};
                shadow_d.dp    = dp_in;
            end
        end
    end

    assign cur_digit = shadow_q.digit[idx_q];

    bcd_to_sseg u_bcd_to_sseg (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

`ifdef SSEG_LZ_BLANK_EN
    logic [N_DIGITS-1:0] lz;

    always_comb begin
        lz    = '0;
        lz[3] = (shadow_q.digit[3] == 4'd0);
        lz[2] = lz[3] && (shadow_q.digit[2] == 4'd0);
        lz[1] = lz[2] && (shadow_q.digit[1] == 4'd0);
    end

    assign blank = lz[idx_q];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        an_d   = 4'b1111;
        sseg_d = 8'hFF;
        if (en) begin
            an_d         = ~(4'b0001 << idx_q);
            sseg_d[7]    = ~shadow_q.dp[idx_q];
            sseg_d[6:0]  = blank ? SEG_OFF : cur_seg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            an_q     <= 4'b1111;
            sseg_q   <= 8'hFF;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            sseg_q   <= sseg_d;
        end
    end

    assign an   = an_q;
    assign sseg = sseg_q;

endmodule

// File: tb/tb_sseg_disp_mux.sv
// Randomized bench for sseg_disp_mux against a frame-level model (enabled-cycle count).
module tb_sseg_disp_mux;

    localparam int unsigned DVSR  = 4;
    localparam int unsigned FRAME = 4 * DVSR;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0, dp_in = '0;
    logic [3:0] an;
    logic [7:0] sseg;

    int vectors = 0;
    int miscompares = 0;

    // Model: enabled edges since last capture, plus the captured frame.
    int         n;
    logic [3:0] sh_d [4];
    logic [3:0] sh_dp;
    logic [3:0] exp_an;
    logic [7:0] exp_sseg;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    sseg_disp_mux #(
        .REFRESH_DVSR (DVSR),
        .REFRESH_W    (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .dp_in (dp_in),
        .an    (an),
        .sseg  (sseg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        n        = 0;
        sh_d     = '{default: 4'd0};
        sh_dp    = 4'd0;
        exp_an   = 4'hF;
        exp_sseg = 8'hFF;
    endtask

    // One clock edge: predict outputs from pre-edge model state, then compare.
    task automatic step();
        int   idx;
        logic blank;
        @(posedge clk);
        idx = (n / DVSR) % 4;
        if (en) begin
            exp_an      = 4'hF;
            exp_an[idx] = 1'b0;
            blank       = 1'b0;
`ifdef SSEG_LZ_BLANK_EN
            if (idx > 0) begin
                blank = 1'b1;
                for (int j = idx; j < 4; j++) if (sh_d[j] != 4'd0) blank = 1'b0;
            end
`endif
            exp_sseg = {~sh_dp[idx], blank ? 7'h7F : seg_tab[sh_d[idx]]};
            n++;
            if (n == FRAME) begin
                n     = 0;
                sh_d  = '{d0, d1, d2, d3};
                sh_dp = dp_in;
            end
        end else begin
            exp_an   = 4'hF;
            exp_sseg = 8'hFF;
        end
        #1;
        check("an", {4'h0, an}, {4'h0, exp_an});
        check("sseg", sseg, exp_sseg);
    endtask

    initial begin
        model_reset();
        d3 = 4'd9; d2 = 4'd8; d1 = 4'd7; d0 = 4'd6; dp_in = 4'd0;
        en = 1'b1;
        #12;
        check("rst_an", {4'h0, an}, 8'h0F);
        check("rst_sseg", sseg, 8'hFF);
        @(negedge clk);
        reset = 1'b1;

        step();
        check("first_an", {4'h0, an}, 8'h0E);
        check("first_sseg", sseg, 8'hC0);
        for (int i = 0; i < 16; i++) step();
        check("frame1_an", {4'h0, an}, 8'h0E);
        check("frame1_sseg", sseg, 8'h82);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    d3 = 4'($urandom_range(0, 15)); d2 = 4'($urandom_range(0, 15));
                    d1 = 4'($urandom_range(0, 15)); d0 = 4'($urandom_range(0, 15));
                end else begin
                    d3 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 9)) : 4'd0;
                    d2 = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 9)) : 4'd0;
                    d1 = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 9)) : 4'd0;
                    d0 = 4'($urandom_range(0, 9));
                end
                dp_in = 4'($urandom_range(0, 15));
            end
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 299) == 0) begin
                #2;
                reset = 1'b0;
                model_reset();
                #1;
                check("async_rst_an", {4'h0, an}, 8'h0F);
                check("async_rst_sseg", sseg, 8'hFF);
                @(negedge clk);
                reset = 1'b1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
